cpu7_csr_timer_array: RTL and testbench
=======================================

# cpu7_csr_timer_array

Parametrised multi-channel timer CSR unit for the cpu7 core. It provides NTIMER independent countdown timers, each with its own TCFG/TVAL/TICLR CSR triple, plus a shared local-interrupt-enable (LIE) mask and a read-only pending-status (ISR) register. It sits beside the CSR file on the same CSR read/write bus and produces a single gated timer interrupt request for ecl. It supersedes the single fixed-width timer, adding channel count, configurable width, per-channel enable masking and one-shot expiry state.

## Interface
- NTIMER, 4: number of timer channels, 1..8
- TIMER_BIT, 32: counter/INITVAL width, ≤ GRLEN-2
- GRLEN, 32: CSR data width
- CSR_BIT, 14: CSR address width
- BASE, 14'h41: CSR address of channel 0 TCFG
- clk  in  1  core clock; one clock domain
- resetn  in  1  asynchronous, active-low reset
- csr_raddr  in  CSR_BIT  read address
- csr_rdata  out  GRLEN  read data, combinational
- csr_waddr  in  CSR_BIT  write address
- csr_wdata  in  GRLEN  write data
- csr_mask  in  GRLEN  per-bit write mask
- csr_wen  in  1  write strobe, sampled on rising clk
- crmd_ie  in  1  global interrupt enable (CRMD.IE)
- timer_intr_vec  out  NTIMER  pending & LIE, per channel
- csr_ecl_timer_intr  out  1  |timer_intr_vec & crmd_ie

## Operation
- Address map: channel k TCFG = BASE+4k, TVAL = BASE+4k+1, TICLR = BASE+4k+2, BASE+4k+3 reserved (reads 0). LIE = BASE+4·NTIMER, ISR = BASE+4·NTIMER+1. Unmapped addresses read 0; writes to them are ignored.
- TCFG layout: bit0 EN, bit1 PERIODIC, [TIMER_BIT+1:2] INITVAL, upper bits read 0. Masked write: new = (old & ~mask) | (wdata & mask).
- TVAL: current counter, zero-extended, read-only. TICLR: reads 0; a write with wdata[0]&mask[0]=1 clears that channel's pending bit. LIE: NTIMER bits, masked write. ISR: pending bits, read-only; writes are ignored.
- Per-channel state machine:
  - IDLE (EN=0): the counter holds its value.
  - RUN: the counter decrements each cycle while nonzero. When the counter is 0, pending is set. If PERIODIC=1, the counter reloads INITVAL and the channel stays in RUN. If PERIODIC=0, the channel goes to DONE.
  - DONE: the counter holds at 0 and pending is not re-set.
- Any TCFG write (address match, irrespective of mask) loads the counter with the post-write INITVAL. The channel then goes to RUN if the post-write EN=1, otherwise to IDLE. This applies from every state, so a write mid-count restarts the timer.
- Pending set and TICLR clear in the same cycle: set wins.
- Outputs are purely combinational from registers and crmd_ie; there is no path from csr_wdata to any output.

## Timing
- Reset (async, asserted low): all TCFG=0, counters=0, states=IDLE, pending=0, LIE=0. Consequently timer_intr_vec=0 and csr_ecl_timer_intr=0 immediately, including when reset is asserted mid-count.
- A TCFG write sampled at edge E0 with INITVAL=N and EN=1 behaves as follows:
  - TVAL=N in the cycle after E0.
  - TVAL=0 after edge EN.
  - pending=1 after edge E(N+1).
  - Periodic mode re-asserts pending every N+1 cycles thereafter. INITVAL=0 in periodic mode sets pending every cycle.
- TICLR write sampled at edge E: pending=0 after E, unless the channel expires at the same edge.
- LIE/crmd_ie changes reflect on outputs in the same cycle (combinational).
- csr_rdata has zero latency and reflects register state before the current cycle's write.
- Counter arithmetic is TIMER_BIT-wide unsigned and never wraps. The DONE/IDLE states prevent decrementing below 0.

## Test plan
- Reset then read every mapped address → all 0; csr_ecl_timer_intr=0.
- Ch0 TCFG write INITVAL=5, EN=1, PERIODIC=0; LIE=1; crmd_ie=1 → TVAL 5,4,…,0; ISR[0]=1 and interrupt high 6 cycles after the write. After TICLR, pending stays 0 forever and TVAL=0.
- Ch2 periodic with INITVAL=3 → ISR[2] re-sets every 4 cycles. TICLR issued in the expiry cycle → pending remains 1.
- Two channels expire with LIE=4'b0010 → timer_intr_vec=4'b0010. Drop crmd_ie → csr_ecl_timer_intr=0 while ISR is unchanged.
- Masked TCFG write with mask=0 mid-count → counter reloads the old INITVAL and the count restarts. Write EN=0 → TVAL freezes.
- resetn pulsed low while ch1 TVAL=2 → all outputs 0 asynchronously. After release, no pending bit sets without a new TCFG write.

Source files
------------

// File: rtl/cpu7_csr_timer_array.sv
// rtl/cpu7_csr_timer_array.sv - multi-channel countdown timer CSR block with LIE mask and pending status
module cpu7_csr_timer_array #(
    parameter int unsigned         NTIMER    = 4,
    parameter int unsigned         TIMER_BIT = 32,
    parameter int unsigned         GRLEN     = 32,
    parameter int unsigned         CSR_BIT   = 14,
    parameter logic [CSR_BIT-1:0]  BASE      = 14'h41
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CSR_BIT-1:0]  csr_raddr,
    output logic [GRLEN-1:0]    csr_rdata,
    input  logic [CSR_BIT-1:0]  csr_waddr,
    input  logic [GRLEN-1:0]    csr_wdata,
    input  logic [GRLEN-1:0]    csr_mask,
    input  logic                csr_wen,
    input  logic                crmd_ie,
    output logic [NTIMER-1:0]   timer_intr_vec,
    output logic                csr_ecl_timer_intr
);

    localparam int unsigned CW = TIMER_BIT + 2;
    localparam int unsigned WW = (CW > GRLEN) ? CW : GRLEN;
    localparam logic [CSR_BIT-1:0] LIE_ADDR = BASE + CSR_BIT'(4 * NTIMER);
    localparam logic [CSR_BIT-1:0] ISR_ADDR = BASE + CSR_BIT'(4 * NTIMER + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    logic [CW-1:0]        tcfg_q [NTIMER];
    logic [CW-1:0]        tcfg_d [NTIMER];
    logic [TIMER_BIT-1:0] cnt_q  [NTIMER];
    logic [TIMER_BIT-1:0] cnt_d  [NTIMER];
    state_e               st_q   [NTIMER];
    state_e               st_d   [NTIMER];
    logic [NTIMER-1:0]    pend_q, pend_d;
    logic [NTIMER-1:0]    lie_q, lie_d;

    // Write data is widened so INITVAL fields wider than the bus simply keep their upper bits.
    logic [WW-1:0] wdata_x, mask_x;
    logic          unused_wbits;

    assign wdata_x      = WW'(csr_wdata);
    assign mask_x       = WW'(csr_mask);
    assign unused_wbits = ^{wdata_x, mask_x};

    function automatic logic [CSR_BIT-1:0] reg_addr(input int k, input int sub);
        return BASE + CSR_BIT'(4 * k + sub);
    endfunction

    always_comb begin
        logic [CW-1:0] cfg_new;
        lie_d  = lie_q;
        pend_d = pend_q;
        for (int k = 0; k < NTIMER; k++) begin
            cfg_new  = '0;
            tcfg_d[k] = tcfg_q[k];
            cnt_d[k]  = cnt_q[k];
            st_d[k]   = st_q[k];

            // Clear is evaluated before expiry so a same-cycle expiry wins.
            if (csr_wen && csr_waddr == reg_addr(k, 2) && csr_wdata[0] && csr_mask[0]) begin
                pend_d[k] = 1'b0;
            end

            case (st_q[k])
                ST_RUN: begin
                    if (cnt_q[k] != '0) begin
                        cnt_d[k] = cnt_q[k] - TIMER_BIT'(1);
                    end else begin
                        pend_d[k] = 1'b1;
                        if (tcfg_q[k][1]) begin
                            cnt_d[k] = tcfg_q[k][CW-1:2];
                        end else begin
                            st_d[k] = ST_DONE;
                        end
                    end
                end
                ST_DONE: cnt_d[k] = '0;
                default: ;
            endcase

            // Any TCFG write restarts the channel from the post-write configuration.
            if (csr_wen && csr_waddr == reg_addr(k, 0)) begin
                cfg_new   = (tcfg_q[k] & ~mask_x[CW-1:0]) | (wdata_x[CW-1:0] & mask_x[CW-1:0]);
                tcfg_d[k] = cfg_new;
                cnt_d[k]  = cfg_new[CW-1:2];
                st_d[k]   = cfg_new[0] ? ST_RUN : ST_IDLE;
            end
        end
        if (csr_wen && csr_waddr == LIE_ADDR) begin
            lie_d = (lie_q & ~csr_mask[NTIMER-1:0]) | (csr_wdata[NTIMER-1:0] & csr_mask[NTIMER-1:0]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NTIMER; k++) begin
                tcfg_q[k] <= '0;
                cnt_q[k]  <= '0;
                st_q[k]   <= ST_IDLE;
            end
            pend_q <= '0;
            lie_q  <= '0;
        end else begin
            for (int k = 0; k < NTIMER; k++) begin
                tcfg_q[k] <= tcfg_d[k];
                cnt_q[k]  <= cnt_d[k];
                st_q[k]   <= st_d[k];
            end
            pend_q <= pend_d;
            lie_q  <= lie_d;
        end
    end

    always_comb begin
        csr_rdata = '0;
        for (int k = 0; k < NTIMER; k++) begin
            if (csr_raddr == reg_addr(k, 0)) begin
                csr_rdata = GRLEN'(tcfg_q[k]);
            end else if (csr_raddr == reg_addr(k, 1)) begin
                csr_rdata = GRLEN'(cnt_q[k]);
            end
        end
        if (csr_raddr == LIE_ADDR) begin
            csr_rdata = GRLEN'(lie_q);
        end else if (csr_raddr == ISR_ADDR) begin
            csr_rdata = GRLEN'(pend_q);
        end
    end

    assign timer_intr_vec     = pend_q & lie_q;
    assign csr_ecl_timer_intr = (|timer_intr_vec) & crmd_ie;

endmodule

// File: tb/tb_cpu7_csr_timer_array.sv
// tb/tb_cpu7_csr_timer_array.sv - scoreboard bench for cpu7_csr_timer_array
module tb_cpu7_csr_timer_array;

    localparam logic [13:0] B = 14'h41;

    logic        clk = 1'b0;
    logic        resetn;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_mask;
    logic        csr_wen;
    logic        crmd_ie;
    logic [3:0]  timer_intr_vec;
    logic        csr_ecl_timer_intr;

    cpu7_csr_timer_array dut (
        .clk                (clk),
        .resetn             (resetn),
        .csr_raddr          (csr_raddr),
        .csr_rdata          (csr_rdata),
        .csr_waddr          (csr_waddr),
        .csr_wdata          (csr_wdata),
        .csr_mask           (csr_mask),
        .csr_wen            (csr_wen),
        .crmd_ie            (crmd_ie),
        .timer_intr_vec     (timer_intr_vec),
        .csr_ecl_timer_intr (csr_ecl_timer_intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    event probe_now;

    function automatic logic [13:0] a_tcfg(input int k);  return B + 14'(4 * k);     endfunction
    function automatic logic [13:0] a_tval(input int k);  return B + 14'(4 * k + 1); endfunction
    function automatic logic [13:0] a_ticlr(input int k); return B + 14'(4 * k + 2); endfunction
    localparam logic [13:0] A_LIE = B + 14'd16;
    localparam logic [13:0] A_ISR = B + 14'd17;

    task automatic tick();
        @(posedge clk);
        #1;
        csr_wen = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        csr_waddr = a;
        csr_wdata = d;
        csr_mask  = m;
        csr_wen   = 1'b1;
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] e, input string n);
        csr_raddr = a;
        q.push_back('{kind: 0, exp: e, name: n});
    endtask

    task automatic ev(input logic [3:0] v, input logic i, input string n);
        q.push_back('{kind: 1, exp: 32'(v), name: {n, "_vec"}});
        q.push_back('{kind: 2, exp: 32'(i), name: {n, "_irq"}});
    endtask

    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk or probe_now);
            while (q.size() > 0) begin
                c = q.pop_front();
                case (c.kind)
                    0:       act = csr_rdata;
                    1:       act = 32'(timer_intr_vec);
                    default: act = 32'(csr_ecl_timer_intr);
                endcase
                n_cmp++;
                if (act !== c.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        crmd_ie   = 1'b1;
        csr_wen   = 1'b0;
        csr_raddr = '0;
        csr_waddr = '0;
        csr_wdata = '0;
        csr_mask  = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int i = -1; i <= 18; i++) begin
            rd(B + 14'(i), 32'h0, "rst_rd");
            if (i == 0) ev(4'b0000, 1'b0, "rst_out");
            tick();
        end

        // channel 0 one-shot, INITVAL=5
        wr(A_LIE, 32'h1, '1);
        tick();
        wr(a_tcfg(0), 32'h15, '1);
        tick();
        for (int j = 0; j <= 5; j++) begin
            rd(a_tval(0), 32'(5 - j), "t0_tval");
            ev(4'b0000, 1'b0, "t0_nopend");
            tick();
        end
        rd(A_ISR, 32'h1, "t0_isr");
        ev(4'b0001, 1'b1, "t0_expire");
        tick();
        rd(a_tval(0), 32'h0, "t0_done_tval");
        wr(a_ticlr(0), 32'h1, 32'h0);
        tick();
        rd(A_ISR, 32'h1, "t0_ticlr_nomask");
        wr(a_ticlr(0), 32'h1, 32'h1);
        tick();
        rd(A_ISR, 32'h0, "t0_clr");
        ev(4'b0000, 1'b0, "t0_clr");
        repeat (8) tick();
        rd(A_ISR, 32'h0, "t0_stays_clr");
        tick();
        rd(a_tval(0), 32'h0, "t0_tval_hold");
        tick();
        rd(a_tcfg(0), 32'h15, "t0_tcfg");
        tick();
        rd(a_ticlr(0), 32'h0, "t0_ticlr_rd");
        tick();

        // channel 2 periodic, INITVAL=3
        wr(a_tcfg(2), 32'hF, '1);
        tick();
        for (int j = 0; j < 4; j++) begin
            rd(A_ISR, 32'h0, "t2_pre");
            tick();
        end
        rd(A_ISR, 32'h4, "t2_expire");
        ev(4'b0000, 1'b0, "t2_masked");
        wr(a_ticlr(2), 32'h1, 32'h1);
        tick();
        rd(A_ISR, 32'h0, "t2_clr");
        tick();
        rd(a_tval(2), 32'h1, "t2_tval");
        tick();
        rd(A_ISR, 32'h0, "t2_before_reset");
        wr(a_ticlr(2), 32'h1, 32'h1);
        tick();
        rd(A_ISR, 32'h4, "t2_set_wins");
        tick();
        rd(a_tval(2), 32'h2, "t2_reload");
        tick();

        // two channels pending, only channel 1 enabled
        wr(A_LIE, 32'h2, '1);
        tick();
        wr(a_tcfg(1), 32'h9, '1);
        tick();
        rd(a_tval(1), 32'h2, "t1_load");
        tick();
        tick();
        rd(A_ISR, 32'h4, "t1_pre");
        ev(4'b0000, 1'b0, "t1_pre");
        tick();
        rd(A_ISR, 32'h6, "two_pend");
        ev(4'b0010, 1'b1, "lie_mask");
        tick();
        crmd_ie = 1'b0;
        rd(A_ISR, 32'h6, "ie_off_isr");
        ev(4'b0010, 1'b0, "ie_off");
        tick();
        crmd_ie = 1'b1;

        // channel 3: mask=0 restart, then EN=0 freeze
        wr(a_tcfg(3), 32'h19, '1);
        tick();
        rd(a_tval(3), 32'h6, "t3_load");
        tick();
        rd(a_tval(3), 32'h5, "t3_dec");
        tick();
        rd(a_tval(3), 32'h4, "t3_dec2");
        wr(a_tcfg(3), 32'hFFFF_FFFF, 32'h0);
        tick();
        rd(a_tval(3), 32'h6, "mask0_reload");
        tick();
        rd(a_tcfg(3), 32'h19, "mask0_keep");
        tick();
        rd(a_tval(3), 32'h4, "restart_count");
        wr(a_tcfg(3), 32'h0, 32'h1);
        tick();
        rd(a_tval(3), 32'h6, "en0_load");
        tick();
        rd(a_tcfg(3), 32'h18, "en0_tcfg");
        tick();
        rd(a_tval(3), 32'h6, "en0_freeze");
        tick();

        // asynchronous reset mid-count on channel 1
        wr(a_tcfg(1), 32'h11, '1);
        tick();
        tick();
        tick();
        rd(a_tval(1), 32'h2, "pre_rst_tval");
        ev(4'b0010, 1'b1, "pre_rst");
        @(negedge clk);
        #1;
        resetn = 1'b0;
        rd(A_ISR, 32'h0, "rst_isr");
        ev(4'b0000, 1'b0, "rst_async");
        #1;
        ->probe_now;
        #1;
        tick();
        tick();
        resetn = 1'b1;
        for (int j = 0; j < 12; j++) begin
            rd(A_ISR, 32'h0, "post_rst_isr");
            if (j == 11) ev(4'b0000, 1'b0, "post_rst");
            tick();
        end
        rd(a_tval(1), 32'h0, "post_rst_tval");
        tick();
        rd(a_tcfg(2), 32'h0, "post_rst_tcfg");
        tick();
        rd(A_LIE, 32'h0, "post_rst_lie");
        tick();
        tick();

        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL queue_drain: %0d left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
